rv_mem_arbiter: RTL and testbench
=================================

# rv_mem_arbiter

Parametrised arbiter that multiplexes N requesters (instruction fetch, data access, debug, and similar) onto the single shared instruction/data memory of the pipelined RV32 core. It generalises the fixed two-way fetch/data address mux:
- arbitrary port count;
- configurable memory read latency with multiple reads in flight;
- a per-port request/grant/response handshake;
- per-port flush of in-flight reads, used to kill wrong-path fetches on taken branches and jumps.

It sits between the pipeline stages and the memory.

## Interface
- NUM_PORTS, 2: number of requesters (≥2). Port 0 is the data (MEM-stage) port.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from an issued read to valid mem_rdata (1..8).

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_PORTS  per-port request; held with stable fields until granted.
- we  in  NUM_PORTS  per-port write enable (1 = store, 0 = load/fetch).
- func3  in  3*NUM_PORTS  per-port access size/sign code; port p at [3p+2:3p].
- addr  in  ADDR_W*NUM_PORTS  per-port byte address, packed like func3.
- wdata  in  DATA_W*NUM_PORTS  per-port store data, packed like func3.
- flush  in  NUM_PORTS  kill all outstanding reads of port p.
- gnt  out  NUM_PORTS  one-hot-or-zero grant, combinational, same cycle as the issue.
- rvalid  out  NUM_PORTS  read data valid for port p.
- rdata  out  DATA_W  read data, shared; qualified by rvalid.
- mem_ready  in  1  memory accepts a command this cycle.
- mem_read  out  1  issue read.
- mem_write  out  1  issue write.
- mem_func3  out  3  func3 of the granted port.
- mem_addr  out  ADDR_W  address of the granted port.
- mem_wdata  out  DATA_W  store data of the granted port.
- mem_rdata  in  DATA_W  memory read data, MEM_LAT cycles after issue.

## Operation
- **Grant.** Each cycle at most one port is granted. A grant requires `rst` high, `mem_ready` = 1 and `req[p]` = 1. The winner is chosen by the arbitration policy (see Configuration).
- **Command outputs.**
  - Granted port with `we` = 1: `mem_write` = 1, `mem_read` = 0.
  - Granted port with `we` = 0: `mem_read` = 1, `mem_write` = 0.
  - `mem_func3`, `mem_addr` and `mem_wdata` mux the granted port's fields.
  - No grant: `mem_read` = `mem_write` = 0, and `mem_addr`/`mem_func3`/`mem_wdata` are 0.
- **Writes.** Complete at the grant and produce no rvalid.
- **Read tracking.** Each issued read pushes {valid, port id} into a MEM_LAT-deep shift pipeline; a non-read cycle pushes valid = 0. The entry leaving the pipeline asserts `rvalid[id]`.
  - `rdata` = `mem_rdata` whenever any rvalid is set, else 0.
  - At most one rvalid per cycle; up to MEM_LAT reads are in flight.
- **Flush.** `flush[p]` clears the valid bit of every pipeline entry tagged p, including the entry emerging in the same cycle, so `rvalid[p]` is suppressed that cycle. A read granted to p in the same cycle as `flush[p]` is not flushed.
- **Ungranted requests.** A request that is not granted stays pending. The requester must keep `req` and its fields stable; the arbiter has no request buffer.

## Timing
- Reset values, asynchronous: gnt = 0, rvalid = 0, rdata = 0, mem_read = mem_write = 0, all pipeline valid bits 0, round-robin pointer = NUM_PORTS-1 (port 0 has first priority).
- Read issued at edge-cycle T appears as `rvalid` at cycle T+MEM_LAT.
- Back-to-back reads give one rvalid per cycle.
- `gnt` is combinational from req/mem_ready/state. The pointer updates on the edge after a grant.
- Reset asserted mid-operation discards all in-flight reads. No rvalid is produced for them after reset release, even if the memory still returns data.
- `mem_ready` = 0 gives no grant, while the pipeline keeps shifting and outstanding reads still complete.
- MEM_LAT outside 1..8 is an elaboration error.

## Configuration
- `RV_MEM_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - Search starts at pointer+1 modulo NUM_PORTS.
  - On a grant, the pointer becomes the granted index.
  - No port waits more than NUM_PORTS-1 grants.
- `RV_MEM_ARB_RR_EN` undefined:
  - Fixed priority: lowest index wins, so the data port 0 always beats fetch.
  - The pointer register is not implemented.

## Test plan
- **Reset then single read:** NUM_PORTS = 2, MEM_LAT = 2, `req[1]` with addr 0x40 and memory returning 0xDEADBEEF → gnt = 2'b10 and mem_read = 1 at T; rvalid = 2'b10 with rdata = 0xDEADBEEF at T+2; nothing at T+1.
- **Contention:** `req[0]` (store 0x1234 at 0x80) and `req[1]` (fetch 0x0) held 3 cycles.
  - Fixed priority: port 0 granted first, then port 1.
  - RR: grants alternate 0, 1, 0.
  - No rvalid for the store.
- **Pipelined reads:** MEM_LAT = 3 with port 1 reading 0x0, 0x4, 0x8 on consecutive cycles → rvalid[1] on three consecutive cycles starting at T+3, with data returned in issue order.
- **Flush:** MEM_LAT = 3, two reads in flight for port 1, `flush[1]` pulsed at T+2 together with a new port-1 grant → the two old rvalids are suppressed; the new read's rvalid appears at T+5.
- **mem_ready / reset:** `mem_ready` = 0 for 2 cycles with `req` = 2'b11 → no gnt, and the in-flight read still returns. Then assert `rst` low mid-flight → all outputs 0 immediately, and no rvalid after release.

Source files
------------

// File: rtl/rv_mem_arbiter_if.sv
// rv_mem_arbiter_if: requester and memory-side bus of the shared-memory arbiter
interface rv_mem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [3*NUM_PORTS-1:0]      func3;
    logic [ADDR_W*NUM_PORTS-1:0] addr;
    logic [DATA_W*NUM_PORTS-1:0] wdata;
    logic [NUM_PORTS-1:0]        flush;
    logic [NUM_PORTS-1:0]        gnt;
    logic [NUM_PORTS-1:0]        rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        mem_ready;
    logic                        mem_read;
    logic                        mem_write;
    logic [2:0]                  mem_func3;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport master (
        output req, we, func3, addr, wdata, flush, mem_ready, mem_rdata,
        input  gnt, rvalid, rdata, mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, func3, addr, wdata, flush, mem_ready, mem_rdata,
        output gnt, rvalid, rdata, mem_read, mem_write, mem_func3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: N-port shared-memory arbiter with pipelined read tracking and per-port flush; round-robin when RV_MEM_ARB_RR_EN is defined, fixed priority otherwise
module rv_mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input logic            clk,
    input logic            rst,
    rv_mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_PORTS);

    if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_lat
        $error("rv_mem_arbiter: MEM_LAT must be within 1..8");
    end
    if (NUM_PORTS < 2) begin : g_bad_ports
        $error("rv_mem_arbiter: NUM_PORTS must be at least 2");
    end

    logic                         hit;
    logic                         out_v;
    logic [IW-1:0]                sel;
    logic [IW-1:0]                idx;
    logic [IW-1:0]                ptr;
    logic [MEM_LAT-1:0]           vld_q, vld_d;
    logic [MEM_LAT-1:0][IW-1:0]   id_q, id_d;

`ifdef RV_MEM_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // remember the last winner so the next search resumes just after it
    always_comb ptr_d = hit ? sel : ptr_q;

    // pointer starts at the last port so port 0 has first priority out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= IW'(NUM_PORTS - 1);
        else      ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = IW'(NUM_PORTS - 1);
`endif

    // first requester after the pointer wins; a pointer pinned at the last port gives lowest-index-first
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_PORTS);
            if (bus.req[idx]) begin
                hit = rst & bus.mem_ready;
                sel = idx;
            end
        end
    end

    // put the granted port's command on the memory bus; everything reads zero without a grant
    always_comb begin
        bus.gnt       = '0;
        bus.gnt[sel]  = hit;
        bus.mem_write = hit & bus.we[sel];
        bus.mem_read  = hit & ~bus.we[sel];
        bus.mem_func3 = hit ? bus.func3[int'(sel)*3 +: 3] : '0;
        bus.mem_addr  = hit ? bus.addr[int'(sel)*ADDR_W +: ADDR_W] : '0;
        bus.mem_wdata = hit ? bus.wdata[int'(sel)*DATA_W +: DATA_W] : '0;
    end

    // shift read tags along, killing in-flight entries of flushed ports; a read issued now survives
    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = bus.mem_read;
        id_d[0]  = sel;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~bus.flush[id_q[i-1]];
            id_d[i]  = id_q[i-1];
        end
    end

    // read-tracking pipeline; reset discards every in-flight read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    // the emerging entry returns memory data to its port unless that port is flushing this cycle
    always_comb begin
        out_v                        = vld_q[MEM_LAT-1] & ~bus.flush[id_q[MEM_LAT-1]];
        bus.rvalid                   = '0;
        bus.rvalid[id_q[MEM_LAT-1]]  = out_v;
        bus.rdata                    = out_v ? bus.mem_rdata : '0;
    end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: scoreboard bench for rv_mem_arbiter with two ports and a three-cycle memory
module tb_rv_mem_arbiter;
    localparam int NP  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    rv_mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    rd_t         exp_q[$];
    rd_t         mem_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        pend [NP];
    logic        pwe  [NP];
    logic [2:0]  pf3  [NP];
    logic [31:0] paddr[NP];
    logic [31:0] pwd  [NP];
`ifdef RV_MEM_ARB_RR_EN
    int          mptr = NP - 1;
`endif

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : ((a ^ 32'hA5A5_0000) + 32'h11);
    endfunction

    function automatic int winner(input logic r0, input logic r1);
`ifdef RV_MEM_ARB_RR_EN
        if (mptr == 1) return r0 ? 0 : (r1 ? 1 : -1);
        return r1 ? 1 : (r0 ? 0 : -1);
`else
        return r0 ? 0 : (r1 ? 1 : -1);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic post(input int p, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        pend[p]  = 1'b1;
        pwe[p]   = w;
        pf3[p]   = f3;
        paddr[p] = a;
        pwd[p]   = d;
    endtask

    task automatic tick(input logic [1:0] fl, input logic rdy, input logic rstv);
        int          w;
        logic [1:0]  egnt, erv;
        logic [31:0] erdata, eaddr, ewd;
        logic [2:0]  ef3;
        logic        ewr, erd;
        @(posedge clk);
        #1;
        rst           = rstv;
        bus.req       = {pend[1], pend[0]};
        bus.we        = {pwe[1], pwe[0]};
        bus.func3     = {pf3[1], pf3[0]};
        bus.addr      = {paddr[1], paddr[0]};
        bus.wdata     = {pwd[1], pwd[0]};
        bus.flush     = fl;
        bus.mem_ready = rdy;
        bus.mem_rdata = 32'hBAD0_0000 | 32'(cyc);
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            bus.mem_rdata = mem_q[0].data;
            void'(mem_q.pop_front());
        end
        if (!rstv) exp_q.delete();
        for (int p = 0; p < NP; p++)
            if (fl[p])
                for (int i = exp_q.size() - 1; i >= 0; i--)
                    if (exp_q[i].port == p && exp_q[i].due < cyc + LAT) exp_q.delete(i);
        w      = (rstv && rdy) ? winner(pend[0], pend[1]) : -1;
        egnt   = (w < 0) ? 2'b00 : 2'(1 << w);
        ewr    = (w >= 0) && pwe[w];
        erd    = (w >= 0) && !pwe[w];
        eaddr  = (w < 0) ? 32'h0 : paddr[w];
        ewd    = (w < 0) ? 32'h0 : pwd[w];
        ef3    = (w < 0) ? 3'h0 : pf3[w];
        erv    = 2'b00;
        erdata = 32'h0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            erv    = 2'(1 << exp_q[0].port);
            erdata = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        check("gnt", 32'(bus.gnt), 32'(egnt));
        check("mem_read", 32'(bus.mem_read), 32'(erd));
        check("mem_write", 32'(bus.mem_write), 32'(ewr));
        check("mem_addr", bus.mem_addr, eaddr);
        check("mem_wdata", bus.mem_wdata, ewd);
        check("mem_func3", 32'(bus.mem_func3), 32'(ef3));
        check("rvalid", 32'(bus.rvalid), 32'(erv));
        check("rdata", bus.rdata, erdata);
        if (w >= 0) begin
            if (!pwe[w]) begin
                exp_q.push_back('{due: cyc + LAT, port: w, data: mem_val(paddr[w])});
                mem_q.push_back('{due: cyc + LAT, port: w, data: mem_val(paddr[w])});
            end
            pend[w] = 1'b0;
`ifdef RV_MEM_ARB_RR_EN
            mptr = w;
`endif
        end
`ifdef RV_MEM_ARB_RR_EN
        if (!rstv) mptr = NP - 1;
`endif
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(2'b00, 1'b1, 1'b1);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            pend[p]  = 1'b0;
            pwe[p]   = 1'b0;
            pf3[p]   = 3'h0;
            paddr[p] = 32'h0;
            pwd[p]   = 32'h0;
        end
        bus.req       = '0;
        bus.we        = '0;
        bus.func3     = '0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.flush     = '0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '0;
        tick(2'b00, 1'b1, 1'b0);
        post(1, 1'b0, 3'b010, 32'h40, 32'h0);
        tick(2'b00, 1'b1, 1'b0);
        idle(5);
        post(0, 1'b1, 3'b010, 32'h80, 32'h1234);
        post(1, 1'b0, 3'b010, 32'h0, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        if (!pend[0]) post(0, 1'b1, 3'b001, 32'h84, 32'h5678);
        tick(2'b00, 1'b1, 1'b1);
        tick(2'b00, 1'b1, 1'b1);
        idle(5);
        post(1, 1'b0, 3'b010, 32'h0, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        post(1, 1'b0, 3'b010, 32'h4, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        post(1, 1'b0, 3'b010, 32'h8, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        idle(4);
        post(1, 1'b0, 3'b010, 32'h100, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        post(1, 1'b0, 3'b010, 32'h104, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        post(1, 1'b0, 3'b010, 32'h108, 32'h0);
        tick(2'b10, 1'b1, 1'b1);
        idle(4);
        post(0, 1'b0, 3'b100, 32'h110, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        tick(2'b10, 1'b1, 1'b1);
        idle(4);
        post(1, 1'b0, 3'b010, 32'h200, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        post(0, 1'b0, 3'b000, 32'h300, 32'h0);
        post(1, 1'b0, 3'b010, 32'h204, 32'h0);
        tick(2'b00, 1'b0, 1'b1);
        tick(2'b00, 1'b0, 1'b1);
        idle(6);
        post(1, 1'b0, 3'b010, 32'h400, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        post(1, 1'b0, 3'b010, 32'h404, 32'h0);
        tick(2'b00, 1'b1, 1'b1);
        tick(2'b00, 1'b1, 1'b0);
        tick(2'b00, 1'b1, 1'b0);
        idle(5);
        post(0, 1'b0, 3'b010, 32'h500, 32'h0);
        post(1, 1'b0, 3'b010, 32'h504, 32'h0);
        idle(7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
